// File: rtl/dso_spi_pkg.sv
// Shared types and constants for the DSO digital-section SPI path.
// Holds the arbiter state enum, slave-select codes and the SPI word width.
package dso_spi_pkg;

    localparam int unsigned SPI_W = 16;

    localparam logic [2:0] SS_TRIG = 3'd0;
    localparam logic [2:0] SS_CH1  = 3'd1;
    localparam logic [2:0] SS_CH2  = 3'd2;
    localparam logic [2:0] SS_CH3  = 3'd3;
    localparam logic [2:0] SS_EEP  = 3'd4;
    localparam logic [2:0] SS_NONE = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StGap
    } arb_state_t;

endpackage

// File: rtl/spi_arbiter_if.sv
// Bundle between the requesters, the SPI arbiter and the SPI master / SS decode.
// The slave modport is the arbiter's view; master is the requester/SPI-master side.
interface spi_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    import dso_spi_pkg::*;

    logic [NUM_REQ-1:0]       req;
    logic [SPI_W*NUM_REQ-1:0] req_cmd;
    logic [3*NUM_REQ-1:0]     req_ss;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     err;
    logic [SPI_W-1:0]         rd_data;
    logic                     busy;
    logic                     wrt_SPI;
    logic [SPI_W-1:0]         SPI_cmd;
    logic [2:0]               ss;
    logic                     SPI_done;
    logic [SPI_W-1:0]         SPI_data_out;

    modport master (
        output req, req_cmd, req_ss, SPI_done, SPI_data_out,
        input  gnt, done, err, rd_data, busy, wrt_SPI, SPI_cmd, ss
    );

    modport slave (
        input  req, req_cmd, req_ss, SPI_done, SPI_data_out,
        output gnt, done, err, rd_data, busy, wrt_SPI, SPI_cmd, ss
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Returns the winner one-hot and its index; both zero when nothing is requested.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    always_comb begin : pick
        int unsigned pos;
        logic        found;
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = (32'(ptr) + k) % NUM_REQ;
            if (!found && req[pos]) begin
                found       = 1'b1;
                winner[pos] = 1'b1;
                idx         = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Optional WAIT watchdog is built only when SPI_ARB_TIMEOUT_EN is defined.
module spi_arbiter
    import dso_spi_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input logic          clk,
    input logic          rst_n,
    spi_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("spi_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
    end

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   w_q, w_d;
    logic [2:0]         ss_q, ss_d;
    logic [SPI_W-1:0]   cmd_q, cmd_d;
    logic [SPI_W-1:0]   rd_q, rd_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               wrt_q, wrt_d;
    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   ptr_after_w;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (pick_oh),
        .idx    (pick_idx)
    );

    assign ptr_after_w = (w_q == IDX_W'(NUM_REQ - 1)) ? '0 : w_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        ss_d    = ss_q;
        cmd_d   = cmd_q;
        rd_d    = rd_q;
        gnt_d   = '0;
        done_d  = '0;
        wrt_d   = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    w_d     = pick_idx;
                    gnt_d   = pick_oh;
                    wrt_d   = 1'b1;
                    cmd_d   = bus.req_cmd[SPI_W*pick_idx +: SPI_W];
                    ss_d    = bus.req_ss[3*pick_idx +: 3];
                    state_d = StWait;
`ifdef SPI_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StWait: begin
                // A done seen while wrt_SPI is still high belongs to the previous transfer.
                if (bus.SPI_done && !wrt_q) begin
                    rd_d        = bus.SPI_data_out;
                    done_d[w_q] = 1'b1;
                    ptr_d       = ptr_after_w;
                    state_d     = StGap;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rd_d        = '1;
                    done_d[w_q] = 1'b1;
                    err_d       = 1'b1;
                    ptr_d       = ptr_after_w;
                    state_d     = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StGap: begin
                ss_d    = SS_NONE;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            w_q     <= '0;
            ss_q    <= SS_NONE;
            cmd_q   <= '0;
            rd_q    <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            wrt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            ss_q    <= ss_d;
            cmd_q   <= cmd_d;
            rd_q    <= rd_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            wrt_q   <= wrt_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.rd_data = rd_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.wrt_SPI = wrt_q;
    assign bus.SPI_cmd = cmd_q;
    assign bus.ss      = ss_q;

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares the single SPI master of the DSO digital section among up to NUM_REQ requesters (command processor, calibration loader, trigger/gain configurators). The arbiter grants round-robin, drives the master's `wrt_SPI`/`cmd` and the 3-bit slave-select code, holds `ss` stable for the whole transaction and returns the read word plus a per-requester done pulse. It sits between the requesters and `SPI_Master`/SS decode; the decode selects nothing for code 3'b111.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 1024: WAIT-state watchdog limit in clk cycles. Used only with SPI_ARB_TIMEOUT_EN.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req`  in  NUM_REQ  level request per requester.
- `req_cmd`  in  16*NUM_REQ  packed SPI command words; requester i uses bits [16i+15:16i].
- `req_ss`  in  3*NUM_REQ  packed slave-select codes; requester i uses bits [3i+2:3i].
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse: command accepted.
- `done`  out  NUM_REQ  one-hot, one-cycle pulse: transaction finished.
- `err`  out  1  high with `done` if the transaction timed out.
- `rd_data`  out  16  last SPI read word; valid from the `done` pulse until the next `done`.
- `busy`  out  1  high in any state other than IDLE.
- `wrt_SPI`  out  1  one-cycle start pulse to the SPI master.
- `SPI_cmd`  out  16  command to the master; registered.
- `ss`  out  3  slave-select code to the SS decode; registered.
- `SPI_done`  in  1  completion pulse from the master.
- `SPI_data_out`  in  16  read data from the master.

## Operation
- **FSM states:** IDLE, WAIT, GAP.
- **IDLE:** if `|req`, pick the winner: first set bit searching from `ptr` upward, modulo NUM_REQ. At the next edge:
  - latch `SPI_cmd` and `ss` from the winner's slices;
  - pulse `gnt[w]` and `wrt_SPI`;
  - go to WAIT.
- **WAIT:** when `SPI_done` is high, at the next edge:
  - `rd_data <= SPI_data_out`;
  - pulse `done[w]`;
  - set `ptr <= (w+1) mod NUM_REQ`;
  - go to GAP.
  - `SPI_done` sampled in the same cycle that `wrt_SPI` is high is ignored as stale.
- **GAP:** one cycle so the SS line deasserts. Then `ss <= 3'b111` and go to IDLE.
- **Requester rules:**
  - hold `req_cmd`/`req_ss` stable while `req` is high and before `gnt`;
  - drop `req` in the cycle after `gnt`, or it is rearbitrated next round;
  - `req` falling before `gnt` withdraws the request with no side effects.
- **Non-winning requesters:** new `req` arriving in WAIT/GAP wait; no grant is lost.
- **Inputs during a transaction:** changes to `req_cmd`/`req_ss` after `gnt` have no effect.
- **Reset values:**
  - all zero: `gnt`, `done`, `err`, `busy`, `wrt_SPI`, `SPI_cmd`, `rd_data`, `ptr`;
  - `ss = 3'b111`;
  - state = IDLE.
- **Reset mid-transaction:** all of the above restored immediately (asynchronous). No `done` is issued for the aborted transfer. The SPI master shares `rst_n`.

## Timing
- `req` seen in IDLE in cycle N → `gnt`/`wrt_SPI` high in cycle N+1.
- `SPI_done` high in cycle M → `done`/`rd_data` valid in cycle M+1.
- GAP occupies cycle M+1. The earliest next `gnt` is cycle M+3 (IDLE in M+2).
- `ss` and `SPI_cmd` are constant from N+1 through M+1.
- `busy` is high from N+1 through M+1.

## Configuration
- **SPI_ARB_TIMEOUT_EN defined:** a counter runs in WAIT, cleared on entry to WAIT. If it reaches TIMEOUT_CYC without `SPI_done`:
  - pulse `done[w]` and `err`;
  - set `rd_data <= 16'hFFFF`;
  - advance `ptr`;
  - go to GAP.
  - A `SPI_done` arriving in the same cycle as the timeout wins: normal completion, `err = 0`.
- **Not defined:** WAIT lasts until `SPI_done`, `err` is tied 0, and no counter is built.

## Structure
- **Shared package `dso_spi_pkg`:**
  - state enum `arb_state_t`;
  - slave-select codes: `SS_TRIG` = 0, `SS_CH1` = 1, `SS_CH2` = 2, `SS_CH3` = 3, `SS_EEP` = 4, `SS_NONE` = 7;
  - `SPI_W` = 16.
- **Sub-module:** one, `rr_pick`. It is combinational: inputs `req` and `ptr`; outputs a one-hot winner and its index.

## Test plan
- **Single request:** `req[1]` with cmd 16'hA5C3 and ss 1. Expect:
  - `gnt[1]` and `wrt_SPI` one cycle later;
  - `SPI_cmd` = A5C3 and `ss` = 1 held;
  - after `SPI_done` with `SPI_data_out` 16'h00B7: `done[1]` and `rd_data` = 00B7;
  - `ss` = 7 after GAP.
- **Contention:** all four `req` high at reset (`ptr` = 0), each dropped after its own `gnt`. Expect grants in order 0, 1, 2, 3, then `req[0]` re-raised is granted 5th.
- **Fairness:** `req[0]` and `req[2]` stay asserted across rounds. Expect alternating grants 0, 2, 0, 2.
- **Stale done:** `SPI_done` forced high in the `wrt_SPI` cycle, then a real `SPI_done` 20 cycles later. Expect `done` only after the later pulse.
- **Timeout (macro on, TIMEOUT_CYC = 16):** no `SPI_done`. Expect `done[w]`, `err` = 1 and `rd_data` = FFFF 16 cycles after WAIT entry; the next requester is granted afterwards.
- **Reset in WAIT:** `rst_n` low mid-transfer. Expect immediately:
  - `ss` = 7;
  - `busy`, `wrt_SPI`, `gnt`, `done` = 0;
  - `ptr` = 0;
  - no `done` after release.
